serial_add_ctrl: RTL and testbench

- Bit-serial adder controller that time-shares one full-adder cell across the bits of a WIDTH-bit addition, LSB first.
- Carry is held in a flip-flop between cycles.
- Accepts operands on a start pulse, sequences WIDTH add cycles, then presents a registered sum and carry-out with a one-cycle done strobe.
- Sits between operand sources (switches or register file) and display/LED logic on the board top level.

---
 rtl/serial_add_ctrl_pkg.sv | 16 +
 rtl/serial_add_ctrl_if.sv | 31 +++
 rtl/serial_add_ctrl_fa_cell.sv | 18 +
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 tb/tb_serial_add_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared types and helpers for the bit-serial adder controller
package serial_add_ctrl_pkg;

    // Controller states; encoding is fixed so board-level debug taps read consistently.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter width: one extra bit beyond clog2 so WIDTH=32 cannot wrap.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result bundle between operand source and serial adder
// Signals:
//   start    : add request, sampled only while the adder is idle
//   a, b     : WIDTH-bit operands, captured on an accepted start
//   cin      : carry-in, captured on an accepted start
//   busy     : adder is working (shift or done phase)
//   done     : one-cycle strobe when sum/cout are updated
//   sum      : registered result, held until the next completion
//   cout     : registered carry-out, held until the next completion
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// rtl/serial_add_ctrl_fa_cell.sv - single-bit full adder shared across all bit positions
// Ports:
//   i_x, i_y : operand bits
//   i_ci     : carry in
//   o_s      : sum bit (xor of all three inputs)
//   o_co     : carry out (majority of the three inputs)
module fa_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_x ^ i_y ^ i_ci;
    assign o_co = (i_x & i_y) | (i_x & i_ci) | (i_y & i_ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller: one full-adder cell, LSB first
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of serial_add_ctrl_if (start/a/b/cin in, busy/done/sum/cout out)
// One add takes WIDTH+2 cycles: accept edge, WIDTH shift edges, one DONE cycle,
// then one IDLE cycle before the next start can be sampled.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic             r_done;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_s_shift;

    fa_cell u_fa_cell (
        .i_x  (r_a_sr[0]),
        .i_y  (r_b_sr[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_c)
    );

    assign w_last = (r_count == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; written as shift/or so WIDTH=1 needs no slice.
    assign w_s_shift = (r_s_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_next = ST_DONE;
            ST_DONE:                 w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // Shift registers, counter, carry and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_carry <= bus.cin;
                        r_count <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_s_sr  <= w_s_shift;
                    r_carry <= w_c;
                    r_count <= r_count + CW'(1);
                    // Last bit: publish result; done register goes high with the DONE state.
                    if (w_last) begin
                        r_sum  <= w_s_shift;
                        r_cout <= w_c;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: all registered except busy, which decodes the state register
    always_comb begin
        bus.busy = (r_state != ST_IDLE);
        bus.done = r_done;
        bus.sum  = r_sum;
        bus.cout = r_cout;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Stimulus for both instances: index 0 is WIDTH=8, index 1 is WIDTH=1
    logic        st [2];
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic        ci [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : 1;

        serial_add_ctrl_if #(.WIDTH(W)) bus ();

        serial_add_ctrl #(.WIDTH(W)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus)
        );

        assign bus.start = st[g];
        assign bus.a     = av[g][W-1:0];
        assign bus.b     = bv[g][W-1:0];
        assign bus.cin   = ci[g];

        // Reference model: edges since acceptance (-1 = idle), pending results,
        // and the value sum/cout should currently present.
        int         cnt  = -1;
        logic [W:0] q[$];
        logic [W:0] last = '0;
        int         n_done = 0;
        logic       prev_done = 1'b0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt  = -1;
                q.delete();
                last = '0;
            end else if (cnt < 0) begin
                if (st[g]) begin
                    q.push_back((W+1)'(av[g][W-1:0]) + (W+1)'(bv[g][W-1:0]) + (W+1)'(ci[g]));
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == W) begin
                    if (q.size() > 0) last = q.pop_front();
                end else if (cnt == W + 1) begin
                    cnt = -1;
                end
            end
        end

        always @(negedge clk) begin
            check_eq($sformatf("busy_w%0d", W), bus.busy, cnt >= 0);
            check_eq($sformatf("done_w%0d", W), bus.done, cnt == W);
            check_eq($sformatf("result_w%0d", W), {bus.cout, bus.sum}, last);
            if (bus.done) begin
                check_eq($sformatf("done_twice_w%0d", W), prev_done, 1'b0);
                n_done++;
            end
            prev_done = bus.done;
        end
    end

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int bc);
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'(a); bv[0] = 32'(b); ci[0] = c;
        @(negedge clk);
        st[0] = 1'b0; av[0] = $urandom; bv[0] = $urandom; ci[0] = ~c;
        lat = -1;
        bc  = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (g_dut[0].bus.busy) bc++;
            if (g_dut[0].bus.done) lat = k;
        end
    endtask

    int lat, bc, nd, base0, base1;
    int dpos[$];

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; av[i] = '0; bv[i] = '0; ci[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_eq("rst_busy", g_dut[0].bus.busy, 1'b0);
        check_eq("rst_done", g_dut[0].bus.done, 1'b0);
        check_eq("rst_sum",  g_dut[0].bus.sum,  8'h00);
        check_eq("rst_cout", g_dut[0].bus.cout, 1'b0);
        rst_n = 1'b1;

        // Basic add with latency and busy length
        add8(8'h5A, 8'h3C, 1'b0, lat, bc);
        check_eq("lat_5a3c", lat, 8);
        check_eq("busy_len", bc, 9);
        check_eq("sum_5a3c", g_dut[0].bus.sum, 8'h96);
        check_eq("cout_5a3c", g_dut[0].bus.cout, 1'b0);

        add8(8'hFF, 8'h01, 1'b0, lat, bc);
        check_eq("sum_ff01", g_dut[0].bus.sum, 8'h00);
        check_eq("cout_ff01", g_dut[0].bus.cout, 1'b1);

        add8(8'hFF, 8'hFF, 1'b1, lat, bc);
        check_eq("sum_ffff1", g_dut[0].bus.sum, 8'hFF);
        check_eq("cout_ffff1", g_dut[0].bus.cout, 1'b1);

        // start held high: back-to-back adds every WIDTH+2 cycles; a disturbed mid-SHIFT
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'h01; bv[0] = 32'h01; ci[0] = 1'b0;
        dpos.delete();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 3) av[0] = 32'hFF;
            if (k == 6) av[0] = 32'h01;
            if (g_dut[0].bus.done) begin
                dpos.push_back(k);
                check_eq("b2b_sum", g_dut[0].bus.sum, 8'h02);
            end
        end
        st[0] = 1'b0;
        check_eq("b2b_count", dpos.size(), 3);
        if (dpos.size() == 3) begin
            check_eq("b2b_pos0", dpos[0], 8);
            check_eq("b2b_pos1", dpos[1], 18);
            check_eq("b2b_pos2", dpos[2], 28);
        end
        repeat (12) @(negedge clk);

        // Asynchronous abort in SHIFT cycle 4
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'h5A; bv[0] = 32'h3C; ci[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        nd = g_dut[0].n_done;
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", g_dut[0].bus.busy, 1'b0);
        check_eq("abort_done", g_dut[0].bus.done, 1'b0);
        check_eq("abort_sum",  g_dut[0].bus.sum,  8'h00);
        check_eq("abort_cout", g_dut[0].bus.cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("abort_no_done", g_dut[0].n_done, nd);
        add8(8'h10, 8'h20, 1'b0, lat, bc);
        check_eq("sum_1020", g_dut[0].bus.sum, 8'h30);
        check_eq("lat_1020", lat, 8);

        // Random regression on both widths; operands churn every cycle
        base0 = g_dut[0].n_done;
        base1 = g_dut[1].n_done;
        for (int cyc = 0; cyc < 40000 &&
             (g_dut[0].n_done - base0 < 1000 || g_dut[1].n_done - base1 < 1000); cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom % 4) != 0;
                av[i] = $urandom;
                bv[i] = $urandom;
                ci[i] = 1'($urandom);
            end
        end
        for (int i = 0; i < 2; i++) st[i] = 1'b0;
        check_eq("regress_w8_count", g_dut[0].n_done - base0 >= 1000, 1'b1);
        check_eq("regress_w1_count", g_dut[1].n_done - base1 >= 1000, 1'b1);
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
